// File: rtl/psu_spi_pkg.sv
// -----------------------------------------------------------------------------
// psu_spi_pkg
//   Shared definitions for the PSU ADC serial transmit path.
//   - SPI_WIDTH_DEF / LEAD_ZEROS_DEF : default sample width and zero padding
//   - frame_bits()                   : total bits in one {zeros,vd,zeros,id} frame
//   - adc_tx_state_t                 : transmitter FSM states
// -----------------------------------------------------------------------------
package psu_spi_pkg;

    localparam int unsigned SPI_WIDTH_DEF  = 12;
    localparam int unsigned LEAD_ZEROS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } adc_tx_state_t;

    // Two padded samples (voltage then current) per frame.
    function automatic int unsigned frame_bits(input int unsigned spi_width,
                                               input int unsigned lead_zeros);
        return 2 * (lead_zeros + spi_width);
    endfunction

endpackage

// File: rtl/adc_spi_tx_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//   Brings an asynchronous input into the clk domain through STAGES flops,
//   then compares against one more register to produce single-cycle edge
//   pulses.
//   Ports:
//     clk_i    system clock
//     n_rst_i  asynchronous active-low reset (all flops load RST_VAL)
//     async_i  asynchronous input
//     level_o  synchronized level
//     rise_o   one-clk pulse on a synchronized 0->1 transition
//     fall_o   one-clk pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module edge_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/adc_spi_tx.sv
// -----------------------------------------------------------------------------
// adc_spi_tx
//   SPI slave transmitter for a voltage/current ADC sample pair. On a cs
//   falling edge the frame {LEAD_ZEROS x 0, vd, LEAD_ZEROS x 0, id} is captured
//   and shifted out MSB first, one bit per sck falling edge. cs and sck are
//   asynchronous and are oversampled by clk.
//
//   Ports:
//     clk          system clock (only clock)
//     n_rst        asynchronous active-low reset
//     test_mode    (ADC_TX_TESTPAT_EN only) send frame counter / ~counter
//     cs           frame select, active-low, async
//     sck          serial clock, async
//     vd_in        voltage sample, captured at frame start
//     id_in        current sample, captured at frame start
//     dout         serial data (0 outside of SHIFT)
//     busy         high in SHIFT and HOLD
//     frame_done   one-clk pulse when the last bit has been clocked out
//     frame_abort  one-clk pulse when cs rises during SHIFT
//
//   Optional feature macro: ADC_TX_TESTPAT_EN
//     Adds test_mode and a SPI_WIDTH frame counter that increments on each
//     frame_done; with test_mode=1 the frame carries counter / ~counter.
// -----------------------------------------------------------------------------
module adc_spi_tx
    import psu_spi_pkg::*;
#(
    parameter int unsigned SPI_WIDTH   = SPI_WIDTH_DEF,
    parameter int unsigned LEAD_ZEROS  = LEAD_ZEROS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
`ifdef ADC_TX_TESTPAT_EN
    input  logic                 test_mode,
`endif
    input  logic                 cs,
    input  logic                 sck,
    input  logic [SPI_WIDTH-1:0] vd_in,
    input  logic [SPI_WIDTH-1:0] id_in,
    output logic                 dout,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int unsigned       FRAME_BITS = frame_bits(SPI_WIDTH, LEAD_ZEROS);
    localparam int unsigned       CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);
    localparam int unsigned       SETTLE_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES);

    // ------------------------------------------------------------------
    // Input synchronizers: cs idles high, sck idles low.
    // ------------------------------------------------------------------
    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic sync_unused;

    edge_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .async_i (cs),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    edge_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sck_sync (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .async_i (sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // Only the sck falling edge drives the shifter.
    assign sync_unused = sck_rise ^ sck_level;

    // ------------------------------------------------------------------
    // Start qualification. The cs synchronizer resets to 1, so a cs that is
    // already low when reset releases would look like a falling edge once
    // the real level reaches the end of the chain. Frames are only accepted
    // after cs has been observed high with a fully refilled synchronizer.
    // ------------------------------------------------------------------
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                armed_q,  armed_d;
    logic                settled;

    assign settled  = (settle_q == SETTLE_MAX);
    assign settle_d = settled ? settle_q : settle_q + SETTLE_W'(1);
    assign armed_d  = armed_q | (settled & cs_level);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample source selection
    // ------------------------------------------------------------------
    logic [SPI_WIDTH-1:0] vd_src, id_src;

`ifdef ADC_TX_TESTPAT_EN
    logic [SPI_WIDTH-1:0] pat_cnt_q, pat_cnt_d;

    assign vd_src = test_mode ? pat_cnt_q  : vd_in;
    assign id_src = test_mode ? ~pat_cnt_q : id_in;
`else
    assign vd_src = vd_in;
    assign id_src = id_in;
`endif

    logic [FRAME_BITS-1:0] frame_word;
    assign frame_word = {{LEAD_ZEROS{1'b0}}, vd_src, {LEAD_ZEROS{1'b0}}, id_src};

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    adc_tx_state_t         state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic                  done_q,  done_d;
    logic                  abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d = SHIFT;
                    shift_d = frame_word;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // cs wins over a coincident sck edge: the frame is abandoned
                // without taking the shift.
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    shift_d = '0;
                end else if (sck_fall) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    if (cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

`ifdef ADC_TX_TESTPAT_EN
    assign pat_cnt_d = done_d ? pat_cnt_q + SPI_WIDTH'(1) : pat_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pat_cnt_q <= '0;
        end else begin
            pat_cnt_q <= pat_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout        = (state_q == SHIFT) & shift_q[FRAME_BITS-1];
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_adc_spi_tx.sv
module tb_adc_spi_tx;

    localparam int W  = 12;
    localparam int LZ = 4;
    localparam int FB = 2 * (W + LZ);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          cs = 1'b1;
    logic          sck = 1'b0;
    logic [W-1:0]  vd_in = '0;
    logic [W-1:0]  id_in = '0;
    logic          dout, busy, frame_done, frame_abort;
`ifdef ADC_TX_TESTPAT_EN
    logic          test_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    adc_spi_tx #(
        .SPI_WIDTH   (W),
        .LEAD_ZEROS  (LZ),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
`ifdef ADC_TX_TESTPAT_EN
        .test_mode   (test_mode),
`endif
        .cs          (cs),
        .sck         (sck),
        .vd_in       (vd_in),
        .id_in       (id_in),
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    typedef struct {
        bit          is_done;
        logic [63:0] word;
        int          nbits;
    } exp_t;

    exp_t expq[$];
    bit   rx_bits[64];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame as the master sees it: vd sits above id, each padded by LZ zeros.
    function automatic logic [63:0] ref_frame(input logic [W-1:0] vd, input logic [W-1:0] id);
        return (64'(vd) << (LZ + W)) | 64'(id);
    endfunction

    // Monitor: every frame_done / frame_abort pulse consumes one expectation.
    initial begin : monitor
        exp_t        e;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            if (frame_done || frame_abort) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: done=%b abort=%b, required no pulse (t=%0t)",
                             frame_done, frame_abort, $time);
                end else begin
                    e = expq.pop_front();
                    check("pulse_done", 64'(frame_done), 64'(e.is_done));
                    check("pulse_abort", 64'(frame_abort), 64'(!e.is_done));
                    got = '0;
                    for (int i = 0; i < e.nbits; i++) got = (got << 1) | 64'(rx_bits[i]);
                    check("rx_word", got, e.word >> (FB - e.nbits));
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // One SPI master transaction. abort_after<0: full run of n_sck clocks.
    // Otherwise cs rises after that many sck falls, or together with that
    // fall when same_edge is set. hi_fix/lo_fix of 0 select random timing.
    task automatic run_frame(input logic [W-1:0] vd, input logic [W-1:0] id,
                             input int n_sck, input int abort_after, input bit same_edge,
                             input bit pat, input int hi_fix, input int lo_fix);
        int          hi, lo, falls, rises;
        exp_t        e;
        falls = n_sck;
        rises = n_sck;
        if (abort_after >= 0) begin
            falls = same_edge ? abort_after - 1 : abort_after;
            rises = abort_after;
        end
        e.is_done = (falls >= FB);
        e.word    = pat ? ref_frame(W'(model_done_cnt), ~W'(model_done_cnt)) : ref_frame(vd, id);
        e.nbits   = e.is_done ? FB : rises;
        expq.push_back(e);
        if (e.is_done) model_done_cnt++;

        vd_in = vd;
        id_in = id;
        for (int i = 0; i < 64; i++) rx_bits[i] = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_in_frame", 64'(busy), 64'd1);
        vd_in = W'($urandom);
        id_in = W'($urandom);
        for (int k = 0; k < n_sck; k++) begin
            hi = (hi_fix > 0) ? hi_fix : int'($urandom_range(4, 8));
            lo = (lo_fix > 0) ? lo_fix : int'($urandom_range(4, 8));
            sck = 1'b1;
            rx_bits[k] = dout;
            repeat (hi) @(negedge clk);
            sck = 1'b0;
            if (abort_after >= 0 && k + 1 == abort_after) begin
                if (same_edge) begin
                    cs = 1'b1;
                end else begin
                    repeat (lo) @(negedge clk);
                    cs = 1'b1;
                end
                break;
            end
            repeat (lo) @(negedge clk);
        end
        if (abort_after < 0 && e.is_done) begin
            check("dout_in_hold", 64'(dout), 64'd0);
            check("busy_in_hold", 64'(busy), 64'd1);
            for (int k = FB; k < n_sck; k++) check("extra_bit_zero", 64'(rx_bits[k]), 64'd0);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_after_frame", 64'(busy), 64'd0);
        check("dout_idle", 64'(dout), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_abort", 64'(frame_abort), 64'd0);
        model_done_cnt = 0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin : stimulus
        logic [W-1:0] rv, ri;
        int           na, ns;

        // Power-on reset with cs idle high.
        repeat (2) @(negedge clk);
        do_reset();
        repeat (6) @(negedge clk);

        // Nominal frame at 5/6 timing.
        run_frame(12'hA5C, 12'h3F1, 32, -1, 1'b0, 1'b0, 5, 6);

        // Abort after 10 falls, then a clean frame.
        run_frame(W'($urandom), W'($urandom), 32, 10, 1'b0, 1'b0, 0, 0);
        run_frame(W'($urandom), W'($urandom), 32, -1, 1'b0, 1'b0, 0, 0);

        // Reset at bit 20 with cs held low across deassertion.
        vd_in = W'($urandom);
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            sck = 1'b1; repeat (5) @(negedge clk);
            sck = 1'b0; repeat (6) @(negedge clk);
        end
        do_reset();
        repeat (6) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            sck = 1'b1; repeat (5) @(negedge clk);
            check("no_start_busy", 64'(busy), 64'd0);
            sck = 1'b0; repeat (6) @(negedge clk);
            check("no_start_dout", 64'(dout), 64'd0);
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
        run_frame(W'($urandom), W'($urandom), 32, -1, 1'b0, 1'b0, 0, 0);

        // cs rise coincident with the 32nd sck fall.
        run_frame(W'($urandom), W'($urandom), 32, 32, 1'b1, 1'b0, 0, 0);

        // 40 sck cycles in one frame.
        run_frame(W'($urandom), W'($urandom), 40, -1, 1'b0, 1'b0, 0, 0);

        // Randomized frames with occasional aborts.
        for (int f = 0; f < 8; f++) begin
            rv = W'($urandom);
            ri = W'($urandom);
            ns = int'($urandom_range(32, 36));
            na = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : -1;
            run_frame(rv, ri, ns, na, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end

`ifdef ADC_TX_TESTPAT_EN
        do_reset();
        repeat (6) @(negedge clk);
        test_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(W'($urandom), W'($urandom), 32, -1, 1'b0, 1'b1, 0, 0);
        end
        test_mode = 1'b0;
`endif

        repeat (10) @(negedge clk);
        check("pending_expectations", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
